avalon_onchip_ram_pipelined: RTL and testbench
==============================================

Name: avalon_onchip_ram_pipelined

Overview:
- Parametrised successor to the fixed 2048x32 single-port on-chip RAM Avalon slave.
- Width, depth and read latency are configurable; read data returns through a readdatavalid pipeline.
- Includes a hardware clear engine that zero-fills the array after reset or on request; waitrequest holds masters off while the clear runs.
- Sits on the system interconnect as an Avalon-MM pipelined slave for processor data/program memory.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, word address width; DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset deassertion; 0 = array contents undefined, block ready immediately.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  global clock enable; when 0 all state freezes.
- chipselect  in  1  slave select.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- writedata  in  DATA_WIDTH  write data.
- clear_req  in  1  single-cycle pulse that starts a zero-fill.
- readdata  out  DATA_WIDTH  read data, valid only when readdatavalid=1.
- readdatavalid  out  1  read data qualifier.
- waitrequest  out  1  1 = request not accepted this cycle.
- busy  out  1  1 while the clear engine is active.

Behaviour:
- Reset values, held while reset_n=0:
  - readdata = 0, readdatavalid = 0.
  - clear address counter = 0; read pipeline valid bits = 0.
  - If CLEAR_ON_RESET=1: state = CLEAR, waitrequest = 1, busy = 1.
  - If CLEAR_ON_RESET=0: state = READY, waitrequest = 0, busy = 0.
- State machine (two states):
  - CLEAR: on each cycle with clken=1, writes all-zero word to the clear counter address, then increments the counter. When the counter equals DEPTH-1, that write completes and the next state is READY; the counter returns to 0.
  - READY: if clear_req=1 and clken=1, next state is CLEAR.
- waitrequest = (state==CLEAR) | ~clken. It is combinational from state and clken.
- Accepted write: chipselect & write & ~waitrequest.
  - Updates only the byte lanes whose byteenable bit is 1.
  - Takes effect on that rising edge.
- Accepted read: chipselect & read & ~write & ~waitrequest.
  - READY accepts one request per cycle, fully pipelined; there are no bubbles.
- chipselect & read & write both high is illegal. The write is performed and the read is dropped; readdatavalid is not generated for it.
- Read latency:
  - Acceptance at edge N gives readdatavalid=1 and readdata valid for the cycle following edge N+READ_LATENCY-1. With READ_LATENCY=1 this is the cycle after acceptance.
  - readdatavalid is high for exactly one cycle per accepted read, and responses return in order.
- Read-during-write to the same address in the same cycle cannot occur, because read and write are mutually exclusive on the port.
- A read accepted on the cycle after a write to the same address returns the new data.
- readdata holds its last value when readdatavalid=0.
- clear_req handling:
  - In READY, reads already in the pipeline complete normally while CLEAR begins.
  - clear_req during CLEAR is ignored; the counter does not restart.
- clken=0 freezes the state, the clear counter, the read pipeline and the output registers. No write or read is accepted.
- reset_n asserted mid-clear or mid-read aborts in-flight reads (no readdatavalid) and returns to the reset values. A subsequent clear starts again from address 0.
- Address arithmetic: the clear counter is ADDR_WIDTH bits and wraps only via the DEPTH-1 terminal compare. Bus addresses are used unmodified, with no aliasing beyond ADDR_WIDTH.
- Storage is inferred RAM. The only output register is the optional second stage.

Test Plan:
1. ADDR_WIDTH=4, CLEAR_ON_RESET=1, after reset_n deasserts:
   - Required: busy=1 and waitrequest=1 for exactly 16 cycles, then both go to 0.
   - Then read all 16 addresses; each returns 0x00000000 with readdatavalid.
2. Write 0xDEADBEEF to address 3 with byteenable=4'b1111, then write 0x11223344 to address 3 with byteenable=4'b0101. Read address 3 -> 0xDE22BE44.
3. READY, READ_LATENCY=2, back-to-back reads of addresses 0, 1, 2 on consecutive cycles (preloaded with 0xA0, 0xA1, 0xA2):
   - Required: readdatavalid high on three consecutive cycles starting 2 cycles after the first acceptance.
   - Required data order: 0xA0, 0xA1, 0xA2.
4. Fill memory with nonzero data, then pulse clear_req with a read of address 5 accepted the same cycle:
   - The read returns the old value.
   - waitrequest=1 for 16 cycles; afterwards address 5 reads 0.
   - A second clear_req pulsed mid-clear does not extend busy.
5. Hold clken=0 for 3 cycles in the middle of a clear and in the middle of a read:
   - The counter, readdatavalid timing and readdata freeze for those cycles, and the total clear time becomes 19 cycles.
6. Assert reset_n=0 at clear address 7, release, and check that a full 16-cycle clear repeats.
   - Also issue a read, then reset before readdatavalid: no readdatavalid appears after reset.

Source files
------------

// File: rtl/avalon_onchip_ram_pipelined.sv
// Purpose: Avalon-MM pipelined slave on-chip RAM with a hardware zero-fill (clear) engine.
// Latency: read data returns READ_LATENCY (1 or 2) enabled cycles after acceptance, in order.
// Backpressure: waitrequest is high while the clear engine runs or clken=0; otherwise one request per cycle.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   clken                   global clock enable; 0 freezes every register and blocks requests
//   chipselect, address,
//   read, write,
//   byteenable, writedata   Avalon-MM slave request side (word addressed)
//   clear_req               one-cycle pulse that starts a zero-fill from READY
//   readdata, readdatavalid read response; readdata holds between responses
//   waitrequest             request not accepted this cycle
//   busy                    clear engine active
module avalon_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clear_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // With CLEAR_ON_RESET=0 the array powers up with whatever it holds and
  // the slave is usable straight out of reset.
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Storage: no reset so it maps onto a RAM macro.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]   rd_dat_q, rd_dat_d;

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdat;
  logic [BE_WIDTH-1:0]     mem_be;

  // ------------------------------------------------------------------
  // Request acceptance
  // ------------------------------------------------------------------
  assign busy        = (state_q == ST_CLEAR);
  assign waitrequest = (state_q == ST_CLEAR) | ~clken;

  // read+write together is illegal on the bus: the write wins and the
  // read is silently dropped, so no response is ever generated for it.
  assign wr_acc = chipselect & write & ~waitrequest;
  assign rd_acc = chipselect & read & ~write & ~waitrequest;

  // ------------------------------------------------------------------
  // Clear FSM and single RAM write port mux
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdat  = writedata;
    mem_be    = byteenable;

    case (state_q)
      ST_CLEAR: begin
        // clear_req is deliberately not looked at here: a second request
        // while clearing must not restart the sweep.
        if (clken) begin
          mem_we   = 1'b1;
          mem_addr = clr_cnt_q;
          mem_wdat = '0;
          mem_be   = '1;
          if (clr_cnt_q == LAST_ADDR) begin
            clr_cnt_d = '0;
            state_d   = ST_READY;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_ONE;
          end
        end
      end
      default: begin
        // wr_acc already folds in clken and the state.
        mem_we = wr_acc;
        if (clken && clear_req) begin
          state_d = ST_CLEAR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][b*8 +: 8] <= mem_wdat[b*8 +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read stage 1: registered RAM output with valid flag.
  // A write on edge N is visible to a read accepted on edge N+1 because the
  // array is read combinationally here and captured on the acceptance edge.
  // Reads already in flight when a clear starts drain normally since the
  // clear only begins overwriting on the edge after clear_req.
  // ------------------------------------------------------------------
  always_comb begin
    rd_vld_d = rd_vld_q;
    rd_dat_d = rd_dat_q;
    if (clken) begin
      rd_vld_d = rd_acc;
      if (rd_acc) begin
        rd_dat_d = mem[address];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  // ------------------------------------------------------------------
  // Optional read stage 2 (READ_LATENCY=2). Any other value behaves as 1.
  // ------------------------------------------------------------------
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

    always_comb begin
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      if (clken) begin
        out_vld_d = rd_vld_q;
        // Only load on a real response so readdata holds between responses.
        if (rd_vld_q) begin
          out_dat_d = rd_dat_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_vld_q <= 1'b0;
        out_dat_q <= '0;
      end else begin
        out_vld_q <= out_vld_d;
        out_dat_q <= out_dat_d;
      end
    end

    assign readdata      = out_dat_q;
    assign readdatavalid = out_vld_q;
  end else begin : g_lat1
    assign readdata      = rd_dat_q;
    assign readdatavalid = rd_vld_q;
  end

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Purpose: self-checking bench; two instances (read latency 1 and 2) share one stimulus stream.
// Latency: responses are matched against a scoreboard holding data and the enabled cycle they are due.
// Backpressure: stimulus only issues requests when the bench expects the slave to be ready.
`timescale 1ns/1ps
module tb_avalon_onchip_ram_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clken;
  logic          chipselect;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic          clear_req;

  logic [DW-1:0] rdata1, rdata2;
  logic          rdv1, rdv2, wr1, wr2, busy1, busy2;

  always #5 clk = ~clk;

  avalon_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_lat1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .clear_req(clear_req), .readdata(rdata1),
    .readdatavalid(rdv1), .waitrequest(wr1), .busy(busy1)
  );

  avalon_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_lat2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .clear_req(clear_req), .readdata(rdata2),
    .readdatavalid(rdv2), .waitrequest(wr2), .busy(busy2)
  );

  typedef struct {
    logic [DW-1:0] dat;
    int            cyc;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] model [DEPTH];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;

  // One bus cycle: sample responses mid-cycle, then let the edge happen.
  // Inputs are driven by the caller 1ns after the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (reset_n && clken) begin
      if (rdv1) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected_lat1 cyc=%0d data=%h required=no response", cyc, rdata1);
        end else begin
          e = q1.pop_front();
          if (rdata1 !== e.dat || cyc != e.cyc) begin
            n_err++;
            $display("FAIL rsp_lat1 got data=%h cyc=%0d required data=%h cyc=%0d", rdata1, cyc, e.dat, e.cyc);
          end
        end
      end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        e = q1.pop_front();
        $display("FAIL rsp_missing_lat1 got no response at cyc=%0d required data=%h cyc=%0d", cyc, e.dat, e.cyc);
      end
      if (rdv2) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected_lat2 cyc=%0d data=%h required=no response", cyc, rdata2);
        end else begin
          e = q2.pop_front();
          if (rdata2 !== e.dat || cyc != e.cyc) begin
            n_err++;
            $display("FAIL rsp_lat2 got data=%h cyc=%0d required data=%h cyc=%0d", rdata2, cyc, e.dat, e.cyc);
          end
        end
      end else if (q2.size() != 0 && q2[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        e = q2.pop_front();
        $display("FAIL rsp_missing_lat2 got no response at cyc=%0d required data=%h cyc=%0d", cyc, e.dat, e.cyc);
      end
    end
    @(posedge clk);
    if (clken) cyc++;
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; byteenable = be; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
    for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_t e;
    e.dat = d; e.cyc = cyc + 1; q1.push_back(e);
    e.cyc = cyc + 2;            q2.push_back(e);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    push_exp(exp_d);
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending lat1=%0d lat2=%0d required 0/0", q1.size(), q2.size());
      q1.delete(); q2.delete();
    end
  endtask

  // Counts cycles the clear engine is busy; optional freeze window and mid-clear clear_req.
  task automatic measure_clear(input string name, input int req_at, input int freeze_at,
                               input int required);
    int n = 0;
    bit bad = 0;
    while (busy1 && n < 100) begin
      if (wr1 !== 1'b1 || wr2 !== 1'b1 || busy2 !== 1'b1) bad = 1;
      clear_req = (n == req_at);
      clken     = !(n >= freeze_at && n < freeze_at + 3);
      n++;
      tick();
    end
    clear_req = 1'b0;
    clken     = 1'b1;
    n_cmp++;
    if (n != required || bad) begin
      n_err++;
      $display("FAIL %s busy cycles=%0d flags_bad=%0d required %0d cycles flags_bad=0", name, n, bad, required);
    end
    n_cmp++;
    if ({wr1, wr2, busy1, busy2} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s_ready got wr/busy=%b required 0000", name, {wr1, wr2, busy1, busy2});
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0; clear_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({rdv1, rdv2, wr1, wr2, busy1, busy2} !== 6'b001111) begin
      n_err++;
      $display("FAIL reset_flags got rdv/wr/busy=%b required 001111", {rdv1, rdv2, wr1, wr2, busy1, busy2});
    end
    n_cmp++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_readdata got %h/%h required 0/0", rdata1, rdata2);
    end
  endtask

  task automatic test_clear_after_reset();
    reset_n = 1'b1;
    measure_clear("clear_after_reset", -1, 1000, 16);
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 32'h0);
    drain();
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 4'b1111, 32'hDEADBEEF);
    do_write(4'd3, 4'b0101, 32'h11223344);
    do_read(4'd3, 32'hDE22BE44);
    do_write(4'd7, 4'b1000, 32'hAABBCCDD);
    do_read(4'd7, 32'hAA000000);
    drain();
  endtask

  task automatic test_back_to_back();
    do_write(4'd0, 4'hF, 32'hA0);
    do_write(4'd1, 4'hF, 32'hA1);
    do_write(4'd2, 4'hF, 32'hA2);
    do_read(4'd0, 32'hA0);
    do_read(4'd1, 32'hA1);
    do_read(4'd2, 32'hA2);
    drain();
    // read+write together: write lands, read gets no response
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 4'd9; byteenable = 4'hF; writedata = 32'h5A5A0009;
    tick();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    do_read(4'd9, 32'h5A5A0009);
    drain();
  endtask

  task automatic test_clear_req();
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 4'hF, 32'hC0DE0000 + a);
    chipselect = 1'b1; read = 1'b1; address = 4'd5; clear_req = 1'b1;
    push_exp(32'hC0DE0005);
    tick();
    chipselect = 1'b0; read = 1'b0; clear_req = 1'b0;
    measure_clear("clear_req", 5, 1000, 16);
    do_read(4'd5, 32'h0);
    do_read(4'd15, 32'h0);
    do_read(4'd0, 32'h0);
    drain();
  endtask

  task automatic test_clken();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    measure_clear("clear_freeze", -1, 4, 19);
    do_write(4'd1, 4'hF, 32'h13579BDF);
    do_write(4'd2, 4'hF, 32'h2468ACE0);
    do_read(4'd1, 32'h13579BDF);
    drain();
    do_read(4'd2, 32'h2468ACE0);
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rdv1, rdv2, wr1, wr2} !== 4'b1011 || rdata1 !== 32'h2468ACE0 || rdata2 !== 32'h13579BDF) begin
        n_err++;
        $display("FAIL read_freeze[%0d] got rdv/wr=%b data=%h/%h required 1011 data=2468ace0/13579bdf",
                 i, {rdv1, rdv2, wr1, wr2}, rdata1, rdata2);
      end
    end
    clken = 1'b1;
    drain();
  endtask

  task automatic test_reset_abort();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    measure_clear("clear_after_abort", -1, 1000, 16);
    do_write(4'd4, 4'hF, 32'hFEEDF00D);
    chipselect = 1'b1; read = 1'b1; address = 4'd4;
    tick();
    chipselect = 1'b0; read = 1'b0;
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({rdv1, rdv2} !== 2'b00 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_err++;
      $display("FAIL read_abort got rdv=%b data=%h/%h required 00 data=0/0", {rdv1, rdv2}, rdata1, rdata2);
    end
    reset_n = 1'b1;
    measure_clear("clear_after_read_abort", -1, 1000, 16);
    repeat (5) tick();
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL final_queue pending lat1=%0d lat2=%0d required 0/0", q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_clear_after_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear_req();
    test_clken();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
